id_ex_stage: RTL and testbench

- ID/EX pipeline register sitting directly upstream of the RV32I execute ALU. It drives the ALU's A, B and ALUControl inputs.
- Captures decoded operands and control from the decode stage behind a valid/ready handshake.
- Resolves data hazards by forwarding from the EX/MEM and MEM/WB stages, and selects the immediate for B.
- Supports back-pressure (stall) and flush (branch/exception kill).

---
 rtl/id_ex_stage_if.sv | 69 ++++++
 rtl/id_ex_stage.sv | 118 +++++++++++
 tb/tb_id_ex_stage.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_stage_if.sv
// ID/EX stage bundle: decode beat, forwarding taps and ALU-side outputs.
// The decode side drives the master modport; the stage uses the slave modport.
interface id_ex_stage_if #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
);
  logic                  flush;
  logic                  in_valid;
  logic                  in_ready;
  logic [XLEN-1:0]       in_pc;
  logic [XLEN-1:0]       in_rs1_data;
  logic [XLEN-1:0]       in_rs2_data;
  logic [XLEN-1:0]       in_imm;
  logic [REG_ADDR_W-1:0] in_rs1_addr;
  logic [REG_ADDR_W-1:0] in_rs2_addr;
  logic [REG_ADDR_W-1:0] in_rd_addr;
  logic [2:0]            in_alu_ctrl;
  logic                  in_use_imm;
  logic                  in_reg_write;
  logic                  in_mem_read;
  logic                  in_mem_write;
  logic                  exmem_fwd_en;
  logic [REG_ADDR_W-1:0] exmem_rd;
  logic [XLEN-1:0]       exmem_data;
  logic                  memwb_fwd_en;
  logic [REG_ADDR_W-1:0] memwb_rd;
  logic [XLEN-1:0]       memwb_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [XLEN-1:0]       A;
  logic [XLEN-1:0]       B;
  logic [2:0]            ALUControl;
  logic [XLEN-1:0]       store_data;
  logic [XLEN-1:0]       out_pc;
  logic [REG_ADDR_W-1:0] out_rd_addr;
  logic                  out_reg_write;
  logic                  out_mem_read;
  logic                  out_mem_write;

  modport master (
    output flush, in_valid, in_pc,
    output in_rs1_data, in_rs2_data, in_imm,
    output in_rs1_addr, in_rs2_addr, in_rd_addr,
    output in_alu_ctrl, in_use_imm,
    output in_reg_write, in_mem_read, in_mem_write,
    output exmem_fwd_en, exmem_rd, exmem_data,
    output memwb_fwd_en, memwb_rd, memwb_data,
    output out_ready,
    input  in_ready, out_valid,
    input  A, B, ALUControl, store_data,
    input  out_pc, out_rd_addr,
    input  out_reg_write, out_mem_read, out_mem_write
  );

  modport slave (
    input  flush, in_valid, in_pc,
    input  in_rs1_data, in_rs2_data, in_imm,
    input  in_rs1_addr, in_rs2_addr, in_rd_addr,
    input  in_alu_ctrl, in_use_imm,
    input  in_reg_write, in_mem_read, in_mem_write,
    input  exmem_fwd_en, exmem_rd, exmem_data,
    input  memwb_fwd_en, memwb_rd, memwb_data,
    input  out_ready,
    output in_ready, out_valid,
    output A, B, ALUControl, store_data,
    output out_pc, out_rd_addr,
    output out_reg_write, out_mem_read, out_mem_write
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the execute ALU.
// Holds one decoded beat, forwards EX/MEM and MEM/WB results onto it.
module id_ex_stage #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input logic          clk,
  input logic          rst_n,
  id_ex_stage_if.slave bus
);

  typedef struct packed {
    logic [XLEN-1:0]       pc;
    logic [XLEN-1:0]       rs1_data;
    logic [XLEN-1:0]       rs2_data;
    logic [XLEN-1:0]       imm;
    logic [REG_ADDR_W-1:0] rs1_addr;
    logic [REG_ADDR_W-1:0] rs2_addr;
    logic [REG_ADDR_W-1:0] rd_addr;
    logic [2:0]            alu_ctrl;
    logic                  use_imm;
    logic                  reg_write;
    logic                  mem_read;
    logic                  mem_write;
  } id_ex_t;

  id_ex_t          r_hold;
  logic            r_valid;
  id_ex_t          w_in;
  logic            w_in_ready;
  logic            w_accept;
  logic [XLEN-1:0] w_fwd_rs1;
  logic [XLEN-1:0] w_fwd_rs2;

  assign w_in_ready = !r_valid || bus.out_ready;
  assign w_accept   = bus.in_valid && w_in_ready;

  always_comb begin
    w_in           = '0;
    w_in.pc        = bus.in_pc;
    w_in.rs1_data  = bus.in_rs1_data;
    w_in.rs2_data  = bus.in_rs2_data;
    w_in.imm       = bus.in_imm;
    w_in.rs1_addr  = bus.in_rs1_addr;
    w_in.rs2_addr  = bus.in_rs2_addr;
    w_in.rd_addr   = bus.in_rd_addr;
    w_in.alu_ctrl  = bus.in_alu_ctrl;
    w_in.use_imm   = bus.in_use_imm;
    w_in.reg_write = bus.in_reg_write;
    w_in.mem_read  = bus.in_mem_read;
    w_in.mem_write = bus.in_mem_write;
  end

  // x0 is hard-wired zero, so it must never pick up a forwarded value
  always_comb begin
    w_fwd_rs1 = r_hold.rs1_data;
    priority case (1'b1)
      (r_hold.rs1_addr == '0):
        w_fwd_rs1 = r_hold.rs1_data;
      (bus.exmem_fwd_en &&
       bus.exmem_rd == r_hold.rs1_addr):
        w_fwd_rs1 = bus.exmem_data;
      (bus.memwb_fwd_en &&
       bus.memwb_rd == r_hold.rs1_addr):
        w_fwd_rs1 = bus.memwb_data;
      default:
        w_fwd_rs1 = r_hold.rs1_data;
    endcase
  end

  always_comb begin
    w_fwd_rs2 = r_hold.rs2_data;
    priority case (1'b1)
      (r_hold.rs2_addr == '0):
        w_fwd_rs2 = r_hold.rs2_data;
      (bus.exmem_fwd_en &&
       bus.exmem_rd == r_hold.rs2_addr):
        w_fwd_rs2 = bus.exmem_data;
      (bus.memwb_fwd_en &&
       bus.memwb_rd == r_hold.rs2_addr):
        w_fwd_rs2 = bus.memwb_data;
      default:
        w_fwd_rs2 = r_hold.rs2_data;
    endcase
  end

  // Stall refresh latches forwarded operands before the producer retires
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_hold  <= '0;
    end else if (bus.flush) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_hold  <= w_in;
    end else if (r_valid && bus.out_ready) begin
      r_valid <= 1'b0;
    end else if (r_valid) begin
      r_hold.rs1_data <= w_fwd_rs1;
      r_hold.rs2_data <= w_fwd_rs2;
    end
  end

  assign bus.in_ready      = w_in_ready;
  assign bus.out_valid     = r_valid;
  assign bus.A             = w_fwd_rs1;
  assign bus.B             = r_hold.use_imm ? r_hold.imm
                                            : w_fwd_rs2;
  assign bus.store_data    = w_fwd_rs2;
  assign bus.ALUControl    = r_hold.alu_ctrl;
  assign bus.out_pc        = r_hold.pc;
  assign bus.out_rd_addr   = r_hold.rd_addr;
  assign bus.out_reg_write = r_valid && r_hold.reg_write;
  assign bus.out_mem_read  = r_valid && r_hold.mem_read;
  assign bus.out_mem_write = r_valid && r_hold.mem_write;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: vector table, corner sequences, random vs model.
// The model tracks one held instruction record plus a valid flag.
module tb_id_ex_stage;
  localparam int XLEN = 32;
  localparam int RW   = 5;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  id_ex_stage_if #(.XLEN(XLEN), .REG_ADDR_W(RW)) bus ();

  id_ex_stage #(.XLEN(XLEN), .REG_ADDR_W(RW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    bus.flush = 0; bus.in_valid = 0; bus.in_pc = 0;
    bus.in_rs1_data = 0; bus.in_rs2_data = 0; bus.in_imm = 0;
    bus.in_rs1_addr = 0; bus.in_rs2_addr = 0; bus.in_rd_addr = 0;
    bus.in_alu_ctrl = 0; bus.in_use_imm = 0;
    bus.in_reg_write = 0; bus.in_mem_read = 0; bus.in_mem_write = 0;
    bus.exmem_fwd_en = 0; bus.exmem_rd = 0; bus.exmem_data = 0;
    bus.memwb_fwd_en = 0; bus.memwb_rd = 0; bus.memwb_data = 0;
    bus.out_ready = 0;
  endtask

  task automatic beat(input logic [31:0] pc,
                      input logic [4:0] a1, input logic [4:0] a2,
                      input logic [31:0] d1, input logic [31:0] d2,
                      input logic [31:0] imm, input logic ui,
                      input logic [2:0] alu, input logic mw);
    bus.in_valid = 1; bus.in_pc = pc;
    bus.in_rs1_addr = a1; bus.in_rs2_addr = a2; bus.in_rd_addr = 5'd9;
    bus.in_rs1_data = d1; bus.in_rs2_data = d2; bus.in_imm = imm;
    bus.in_use_imm = ui; bus.in_alu_ctrl = alu;
    bus.in_reg_write = !mw; bus.in_mem_read = 0; bus.in_mem_write = mw;
  endtask

  typedef struct {
    logic [4:0]  rs1a, rs2a;
    logic [31:0] d1, d2, imm;
    logic        ui;
    logic        ex_en;
    logic [4:0]  ex_rd;
    logic [31:0] ex_d;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_d;
    logic [31:0] ea, eb, esd;
  } vec_t;

  vec_t vt[10];

  // Reference model
  typedef struct {
    logic [31:0] pc, d1, d2, imm;
    logic [4:0]  a1, a2, rd;
    logic [2:0]  alu;
    logic        ui, rw, mr, mw;
  } rec_t;

  rec_t m_rec;
  bit   m_valid;

  function automatic logic [31:0] fwd(input logic [4:0] a,
                                      input logic [31:0] d);
    if (a == 0) return d;
    if (bus.exmem_fwd_en && bus.exmem_rd == a) return bus.exmem_data;
    if (bus.memwb_fwd_en && bus.memwb_rd == a) return bus.memwb_data;
    return d;
  endfunction

  task automatic model_step();
    bit rdy;
    rdy = !m_valid || bus.out_ready;
    if (bus.flush) m_valid = 0;
    else if (bus.in_valid && rdy) begin
      m_valid = 1;
      m_rec.pc = bus.in_pc; m_rec.d1 = bus.in_rs1_data;
      m_rec.d2 = bus.in_rs2_data; m_rec.imm = bus.in_imm;
      m_rec.a1 = bus.in_rs1_addr; m_rec.a2 = bus.in_rs2_addr;
      m_rec.rd = bus.in_rd_addr; m_rec.alu = bus.in_alu_ctrl;
      m_rec.ui = bus.in_use_imm; m_rec.rw = bus.in_reg_write;
      m_rec.mr = bus.in_mem_read; m_rec.mw = bus.in_mem_write;
    end else if (m_valid && bus.out_ready) m_valid = 0;
    else if (m_valid) begin
      m_rec.d1 = fwd(m_rec.a1, m_rec.d1);
      m_rec.d2 = fwd(m_rec.a2, m_rec.d2);
    end
  endtask

  task automatic model_check();
    logic [31:0] f2;
    f2 = fwd(m_rec.a2, m_rec.d2);
    chk("r_valid", 32'(bus.out_valid), 32'(m_valid));
    chk("r_in_ready", 32'(bus.in_ready),
        32'(!m_valid || bus.out_ready));
    chk("r_reg_write", 32'(bus.out_reg_write), 32'(m_valid && m_rec.rw));
    chk("r_mem_read", 32'(bus.out_mem_read), 32'(m_valid && m_rec.mr));
    chk("r_mem_write", 32'(bus.out_mem_write), 32'(m_valid && m_rec.mw));
    if (m_valid) begin
      chk("r_A", bus.A, fwd(m_rec.a1, m_rec.d1));
      chk("r_B", bus.B, m_rec.ui ? m_rec.imm : f2);
      chk("r_store", bus.store_data, f2);
      chk("r_alu", 32'(bus.ALUControl), 32'(m_rec.alu));
      chk("r_pc", bus.out_pc, m_rec.pc);
      chk("r_rd", 32'(bus.out_rd_addr), 32'(m_rec.rd));
    end
  endtask

  initial begin
    vt[0] = '{1, 2, 5, 7, 0, 0, 0, 0, 0, 0, 0, 0, 5, 7, 7};
    vt[1] = '{1, 2, 10, 7, 32'hFFFFFFFC, 1, 0, 0, 0, 0, 0, 0,
              10, 32'hFFFFFFFC, 7};
    vt[2] = '{3, 2, 1, 7, 0, 0, 1, 3, 'h11, 1, 3, 'h22, 'h11, 7, 7};
    vt[3] = '{3, 2, 1, 7, 0, 0, 0, 3, 'h11, 1, 3, 'h22, 'h22, 7, 7};
    vt[4] = '{0, 2, 0, 7, 0, 0, 1, 0, 'h11, 1, 0, 'h22, 0, 7, 7};
    vt[5] = '{0, 0, 'h99, 'h66, 0, 0, 1, 0, 'h11, 1, 0, 'h22,
              'h99, 'h66, 'h66};
    vt[6] = '{3, 4, 8, 7, 0, 0, 1, 4, 'h55, 0, 0, 0, 8, 'h55, 'h55};
    vt[7] = '{3, 4, 8, 7, 'hAB, 1, 0, 0, 0, 1, 4, 'h77, 8, 'hAB, 'h77};
    vt[8] = '{3, 4, 8, 7, 0, 0, 1, 5, 'h11, 1, 6, 'h22, 8, 7, 7};
    vt[9] = '{2, 2, 1, 2, 0, 0, 0, 0, 0, 1, 2, 'h33, 'h33, 'h33, 'h33};

    idle();
    #2;
    chk("rst_valid", 32'(bus.out_valid), 0);
    chk("rst_A", bus.A, 0);
    chk("rst_B", bus.B, 0);
    chk("rst_store", bus.store_data, 0);
    chk("rst_pc", bus.out_pc, 0);
    chk("rst_alu", 32'(bus.ALUControl), 0);
    chk("rst_ctl", 32'({bus.out_reg_write, bus.out_mem_read,
                        bus.out_mem_write}), 0);
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    @(negedge clk);
    rst_n = 1;

    // Latency: accepted beat visible one edge later
    @(negedge clk);
    beat(32'h100, 1, 2, 5, 7, 0, 0, 3'b000, 0);
    bus.out_ready = 1;
    @(posedge clk); #1;
    chk("lat_valid", 32'(bus.out_valid), 1);
    chk("lat_A", bus.A, 5);
    chk("lat_B", bus.B, 7);
    chk("lat_alu", 32'(bus.ALUControl), 0);

    // Forwarding / operand-mapping table
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      idle();
      beat(32'h40 + 32'(i), vt[i].rs1a, vt[i].rs2a, vt[i].d1, vt[i].d2,
           vt[i].imm, vt[i].ui, 3'(i), 0);
      bus.out_ready = 1;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 0; bus.out_ready = 0;
      bus.exmem_fwd_en = vt[i].ex_en; bus.exmem_rd = vt[i].ex_rd;
      bus.exmem_data = vt[i].ex_d;
      bus.memwb_fwd_en = vt[i].wb_en; bus.memwb_rd = vt[i].wb_rd;
      bus.memwb_data = vt[i].wb_d;
      #1;
      chk($sformatf("vec%0d_A", i), bus.A, vt[i].ea);
      chk($sformatf("vec%0d_B", i), bus.B, vt[i].eb);
      chk($sformatf("vec%0d_store", i), bus.store_data, vt[i].esd);
    end

    // Stall with a one-cycle forward from EX/MEM
    @(negedge clk);
    idle();
    beat(32'h200, 1, 4, 1, 7, 0, 0, 3'b010, 0);
    bus.out_ready = 1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 0; bus.out_ready = 0;
    bus.exmem_fwd_en = 1; bus.exmem_rd = 4; bus.exmem_data = 'h55;
    #1 chk("stall1_B", bus.B, 'h55);
    chk("stall1_in_ready", 32'(bus.in_ready), 0);
    @(negedge clk);
    bus.exmem_fwd_en = 0;
    beat(32'h300, 1, 2, 3, 4, 0, 0, 3'b001, 0);
    #1 chk("stall2_B", bus.B, 'h55);
    chk("stall2_in_ready", 32'(bus.in_ready), 0);
    @(negedge clk);
    #1 chk("stall3_B", bus.B, 'h55);
    chk("stall3_in_ready", 32'(bus.in_ready), 0);
    chk("stall3_pc", bus.out_pc, 'h200);
    bus.out_ready = 1;
    #1 chk("stall_release_rdy", 32'(bus.in_ready), 1);
    @(posedge clk); #1;
    chk("stall_take_pc", bus.out_pc, 'h300);
    chk("stall_take_valid", 32'(bus.out_valid), 1);

    // Flush a held store while a new beat is offered
    @(negedge clk);
    beat(32'h400, 1, 2, 3, 4, 0, 0, 3'b000, 1);
    @(posedge clk); #1;
    chk("store_mw", 32'(bus.out_mem_write), 1);
    @(negedge clk);
    bus.out_ready = 0; bus.flush = 1;
    beat(32'h500, 1, 2, 3, 4, 0, 0, 3'b000, 1);
    @(posedge clk); #1;
    chk("flush_valid", 32'(bus.out_valid), 0);
    chk("flush_mw", 32'(bus.out_mem_write), 0);
    @(negedge clk);
    bus.flush = 0; bus.in_valid = 0;
    @(posedge clk); #1;
    chk("flush_dropped", 32'(bus.out_valid), 0);

    // Back-to-back stream, then asynchronous reset mid-stream
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      beat(32'h1000 + 32'(4 * i), 1, 2, 32'(i + 1), 0, 0, 0, 3'b000, 0);
      bus.out_ready = 1;
      @(posedge clk); #1;
      chk($sformatf("b2b%0d_valid", i), 32'(bus.out_valid), 1);
      chk($sformatf("b2b%0d_pc", i), bus.out_pc, 32'h1000 + 32'(4 * i));
      chk($sformatf("b2b%0d_A", i), bus.A, 32'(i + 1));
    end
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("arst_valid", 32'(bus.out_valid), 0);
    chk("arst_A", bus.A, 0);
    chk("arst_pc", bus.out_pc, 0);
    chk("arst_rw", 32'(bus.out_reg_write), 0);
    @(negedge clk);
    idle();
    rst_n = 1;
    m_valid = 0;
    m_rec = '{default: '0};

    // Randomized run against the model
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      bus.flush = ($urandom_range(0, 11) == 0);
      bus.in_valid = ($urandom_range(0, 9) < 6);
      bus.out_ready = ($urandom_range(0, 9) < 6);
      bus.in_pc = $urandom;
      bus.in_rs1_data = $urandom; bus.in_rs2_data = $urandom;
      bus.in_imm = $urandom;
      bus.in_rs1_addr = 5'($urandom_range(0, 3));
      bus.in_rs2_addr = 5'($urandom_range(0, 3));
      bus.in_rd_addr = 5'($urandom);
      bus.in_alu_ctrl = 3'($urandom);
      bus.in_use_imm = 1'($urandom);
      bus.in_reg_write = 1'($urandom);
      bus.in_mem_read = 1'($urandom);
      bus.in_mem_write = 1'($urandom);
      bus.exmem_fwd_en = 1'($urandom);
      bus.exmem_rd = 5'($urandom_range(0, 3));
      bus.exmem_data = $urandom;
      bus.memwb_fwd_en = 1'($urandom);
      bus.memwb_rd = 5'($urandom_range(0, 3));
      bus.memwb_data = $urandom;
      #1 model_check();
      @(posedge clk);
      model_step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
